line_word_packer: RTL and testbench

- Parametrised successor to the camera-path pixel packer.
- Packs a narrow sensor word stream of g_DWIDTH_I bits into g_DWIDTH_O-bit DDR/AXI write words.
- Flushes a zero-padded partial word with lane-valid mask at each line end, tags the last word of each line, and drives a valid/ready output towards the DDR write FIFO.
- Also reports per-line/per-frame statistics and a DDR-write start strobe; sits between the RAW Bayer capture and the DDR write controller.

---
 rtl/line_word_packer.sv | 181 ++++++++++++++++++
 tb/tb_line_word_packer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_word_packer.sv
`default_nettype none
// ============================================================================
// Module : line_word_packer
// Packs narrow sensor words into wide DDR write words, flushing a masked
// partial word at each line end, with line/frame statistics.
// Rev    : 1.0  initial release
// ============================================================================
module line_word_packer #(
    parameter int g_DWIDTH_I  = 32,
    parameter int g_DWIDTH_O  = 512,
    parameter bit g_MSB_FIRST = 1'b0,
    parameter int g_START_LEN = 4
) (
    input  logic                               sys_clk_i,
    input  logic                               rst_i,
    input  logic                               frame_valid_i,
    input  logic                               data_valid_i,
    input  logic [g_DWIDTH_I-1:0]              data_i,
    output logic                               m_valid_o,
    input  logic                               m_ready_i,
    output logic [g_DWIDTH_O-1:0]              m_data_o,
    output logic [g_DWIDTH_O/g_DWIDTH_I-1:0]   m_keep_o,
    output logic                               m_last_o,
    output logic                               start_ddr_w_o,
    output logic [15:0]                        h_count_o,
    output logic [15:0]                        v_count_o,
    output logic [31:0]                        frame_beats_o,
    output logic                               ovf_o
);

    localparam int c_R  = g_DWIDTH_O / g_DWIDTH_I;
    localparam int c_CW = $clog2(c_R);

    logic [c_CW-1:0]       r_cnt;
    logic [g_DWIDTH_O-1:0] r_pack;
    logic                  r_pend;
    logic                  r_dv_d1;
    logic                  r_fv_d1;
    logic [15:0]           r_hc;
    logic [31:0]           r_beats;
    logic [3:0]            r_start_cnt;

    logic                  r_m_valid;
    logic [g_DWIDTH_O-1:0] r_m_data;
    logic [c_R-1:0]        r_m_keep;
    logic                  r_m_last;
    logic                  r_start;
    logic [15:0]           r_h_count;
    logic [15:0]           r_v_count;
    logic [31:0]           r_frame_beats;
    logic                  r_ovf;

    logic                  w_v;
    logic                  w_fe;
    logic                  w_sof;
    logic                  w_eof;
    logic                  w_xfer;
    logic                  w_load;
    logic                  w_last;
    logic [c_CW-1:0]       w_lane;
    logic [c_R-1:0]        w_keep;
    logic [g_DWIDTH_O-1:0] w_pack_nxt;

    assign w_v    = data_valid_i & frame_valid_i;
    assign w_fe   = r_dv_d1 & ~w_v;
    assign w_sof  = frame_valid_i & ~r_fv_d1;
    assign w_eof  = ~frame_valid_i & r_fv_d1;
    // A full word and a partial flush are mutually exclusive: pend implies cnt==0.
    assign w_xfer = r_pend | (w_fe & (r_cnt != '0));
    assign w_load = w_xfer & (~r_m_valid | m_ready_i);
    assign w_last = r_pend ? ~w_v : 1'b1;
    assign w_lane = g_MSB_FIRST ? ~r_cnt : r_cnt;

    always_comb begin
        w_keep = '0;
        for (int k = 0; k < c_R; k++) begin
            if (r_pend)
                w_keep[k] = 1'b1;
            else if (g_MSB_FIRST)
                w_keep[k] = (k >= c_R - int'(r_cnt));
            else
                w_keep[k] = (k < int'(r_cnt));
        end
    end

    // First lane of a word wipes the rest so unused lanes always read zero.
    always_comb begin
        w_pack_nxt = (r_cnt == '0) ? '0 : r_pack;
        w_pack_nxt[int'(w_lane) * g_DWIDTH_I +: g_DWIDTH_I] = data_i;
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            r_cnt         <= '0;
            r_pack        <= '0;
            r_pend        <= 1'b0;
            r_dv_d1       <= 1'b0;
            r_fv_d1       <= 1'b0;
            r_hc          <= '0;
            r_beats       <= '0;
            r_start_cnt   <= '0;
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_m_keep      <= '0;
            r_m_last      <= 1'b0;
            r_start       <= 1'b0;
            r_h_count     <= '0;
            r_v_count     <= '0;
            r_frame_beats <= '0;
            r_ovf         <= 1'b0;
        end else begin
            r_dv_d1 <= w_v;
            r_fv_d1 <= frame_valid_i;
            r_pend  <= w_v & (&r_cnt);

            if (w_v) begin
                r_pack <= w_pack_nxt;
                r_cnt  <= r_cnt + c_CW'(1);
            end else if (w_fe) begin
                r_cnt  <= '0;
            end

            if (w_load) begin
                r_m_valid <= 1'b1;
                r_m_data  <= r_pack;
                r_m_keep  <= w_keep;
                r_m_last  <= w_last;
            end else if (m_ready_i) begin
                r_m_valid <= 1'b0;
            end

            if (w_sof)
                r_ovf <= 1'b0;
            else if (w_xfer & ~w_load)
                r_ovf <= 1'b1;

            if (w_v) begin
                r_hc <= r_hc + 16'd1;
            end else if (w_fe) begin
                r_h_count <= r_hc;
                r_hc      <= '0;
            end

            if (w_sof)
                r_v_count <= '0;
            else if (w_fe)
                r_v_count <= r_v_count + 16'd1;

            if (w_sof)
                r_beats <= '0;
            else if (w_load)
                r_beats <= r_beats + 32'd1;

            // A flush loaded on the frame's final edge still belongs to that frame.
            if (w_eof)
                r_frame_beats <= r_beats + {31'd0, w_load};

            if (w_load & w_last) begin
                r_start_cnt <= 4'(g_START_LEN - 1);
                r_start     <= 1'b1;
            end else if (r_start_cnt != '0) begin
                r_start_cnt <= r_start_cnt - 4'd1;
                r_start     <= 1'b1;
            end else begin
                r_start     <= 1'b0;
            end
        end
    end

    assign m_valid_o     = r_m_valid;
    assign m_data_o      = r_m_data;
    assign m_keep_o      = r_m_keep;
    assign m_last_o      = r_m_last;
    assign start_ddr_w_o = r_start;
    assign h_count_o     = r_h_count;
    assign v_count_o     = r_v_count;
    assign frame_beats_o = r_frame_beats;
    assign ovf_o         = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_line_word_packer.sv
`default_nettype none
// ============================================================================
// Module : tb_line_word_packer
// Scoreboard bench for line_word_packer (LSB-first and MSB-first instances).
// Rev    : 1.0  initial release
// ============================================================================
module tb_line_word_packer;

    localparam int c_WI = 32;
    localparam int c_WO = 512;
    localparam int c_R  = 16;

    typedef struct packed {
        logic [c_WO-1:0] d;
        logic [c_R-1:0]  k;
        logic            l;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic            a_fv = 1'b0, a_dv = 1'b0, a_ready = 1'b1;
    logic [c_WI-1:0] a_d = '0;
    logic            a_valid, a_last, a_start, a_ovf;
    logic [c_WO-1:0] a_data;
    logic [c_R-1:0]  a_keep;
    logic [15:0]     a_h, a_v;
    logic [31:0]     a_fb;

    logic            b_fv = 1'b0, b_dv = 1'b0, b_ready = 1'b1;
    logic [c_WI-1:0] b_d = '0;
    logic            b_valid, b_last, b_start, b_ovf;
    logic [c_WO-1:0] b_data;
    logic [c_R-1:0]  b_keep;
    logic [15:0]     b_h, b_v;
    logic [31:0]     b_fb;

    beat_t exp_a[$], obs_a[$], exp_b[$], obs_b[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    a_start_hi = 0;
    int    b_start_hi = 0;

    always #5 clk = ~clk;

    line_word_packer #(
        .g_DWIDTH_I(c_WI), .g_DWIDTH_O(c_WO), .g_MSB_FIRST(1'b0), .g_START_LEN(4)
    ) u_dut (
        .sys_clk_i(clk), .rst_i(rst), .frame_valid_i(a_fv), .data_valid_i(a_dv),
        .data_i(a_d), .m_valid_o(a_valid), .m_ready_i(a_ready), .m_data_o(a_data),
        .m_keep_o(a_keep), .m_last_o(a_last), .start_ddr_w_o(a_start),
        .h_count_o(a_h), .v_count_o(a_v), .frame_beats_o(a_fb), .ovf_o(a_ovf)
    );

    line_word_packer #(
        .g_DWIDTH_I(c_WI), .g_DWIDTH_O(c_WO), .g_MSB_FIRST(1'b1), .g_START_LEN(1)
    ) u_msb (
        .sys_clk_i(clk), .rst_i(rst), .frame_valid_i(b_fv), .data_valid_i(b_dv),
        .data_i(b_d), .m_valid_o(b_valid), .m_ready_i(b_ready), .m_data_o(b_data),
        .m_keep_o(b_keep), .m_last_o(b_last), .start_ddr_w_o(b_start),
        .h_count_o(b_h), .v_count_o(b_v), .frame_beats_o(b_fb), .ovf_o(b_ovf)
    );

    // Advance one clock; record every accepted output word and strobe cycle.
    task automatic step();
        @(negedge clk);
        if (a_valid && a_ready) obs_a.push_back({a_data, a_keep, a_last});
        if (b_valid && b_ready) obs_b.push_back({b_data, b_keep, b_last});
        if (a_start) a_start_hi++;
        if (b_start) b_start_hi++;
        @(posedge clk);
        #1;
    endtask

    task automatic model_line(input bit to_b, input bit msb, input int n,
                              input logic [31:0] base);
        beat_t w;
        int    lane;
        w = '0;
        for (int i = 0; i < n; i++) begin
            lane = msb ? (c_R - 1 - (i % c_R)) : (i % c_R);
            w.d[lane*c_WI +: c_WI] = base + i;
            w.k[lane] = 1'b1;
            if ((i % c_R) == c_R - 1 || i == n - 1) begin
                w.l = (i == n - 1);
                if (to_b) exp_b.push_back(w);
                else      exp_a.push_back(w);
                w = '0;
            end
        end
    endtask

    task automatic drive_line(input bit to_b, input int n, input logic [31:0] base);
        model_line(to_b, to_b, n, base);
        for (int i = 0; i < n; i++) begin
            if (to_b) begin b_dv = 1'b1; b_d = base + i; end
            else      begin a_dv = 1'b1; a_d = base + i; end
            step();
        end
        a_dv = 1'b0;
        b_dv = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        n_tests++;
        if ({a_valid, a_data, a_keep, a_last, a_start, a_h, a_v, a_fb, a_ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_a got valid=%b keep=%h h=%0d v=%0d fb=%0d ovf=%b want all zero",
                     a_valid, a_keep, a_h, a_v, a_fb, a_ovf);
        end
        n_tests++;
        if ({b_valid, b_data, b_keep, b_last, b_start, b_h, b_v, b_fb, b_ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_b got valid=%b keep=%h h=%0d v=%0d fb=%0d ovf=%b want all zero",
                     b_valid, b_keep, b_h, b_v, b_fb, b_ovf);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_two_words();
        beat_t e, o;
        a_fv = 1'b1;
        step();
        a_start_hi = 0;
        drive_line(1'b0, 32, 32'd0);
        repeat (8) step();
        n_tests++;
        if (obs_a.size() != 2) begin
            n_fail++; $display("FAIL two_words_count got=%0d want=2", obs_a.size());
        end
        while (exp_a.size() != 0 && obs_a.size() != 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL two_words_beat got=%h want=%h", o, e); end
        end
        exp_a.delete(); obs_a.delete();
        n_tests++;
        if (a_h !== 16'd32) begin n_fail++; $display("FAIL two_words_h got=%0d want=32", a_h); end
        n_tests++;
        if (a_v !== 16'd1) begin n_fail++; $display("FAIL two_words_v got=%0d want=1", a_v); end
        n_tests++;
        if (a_start_hi != 4) begin
            n_fail++; $display("FAIL two_words_start_len got=%0d want=4", a_start_hi);
        end
    endtask

    task automatic test_partial();
        beat_t e, o;
        a_fv = 1'b0;
        step();
        n_tests++;
        if (a_fb !== 32'd2) begin n_fail++; $display("FAIL partial_prev_fb got=%0d want=2", a_fb); end
        a_fv = 1'b1;
        step();
        n_tests++;
        if (a_v !== 16'd0 || a_h !== 16'd32) begin
            n_fail++; $display("FAIL partial_sof got v=%0d h=%0d want v=0 h=32", a_v, a_h);
        end
        drive_line(1'b0, 20, 32'd0);
        repeat (6) step();
        n_tests++;
        if (obs_a.size() != 2) begin
            n_fail++; $display("FAIL partial_count got=%0d want=2", obs_a.size());
        end
        while (exp_a.size() != 0 && obs_a.size() != 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL partial_beat got=%h want=%h", o, e); end
        end
        exp_a.delete(); obs_a.delete();
        n_tests++;
        if (a_h !== 16'd20 || a_v !== 16'd1) begin
            n_fail++; $display("FAIL partial_stats got h=%0d v=%0d want h=20 v=1", a_h, a_v);
        end
    endtask

    task automatic test_msb_first();
        beat_t e, o;
        b_fv = 1'b1;
        step();
        b_start_hi = 0;
        drive_line(1'b1, 3, 32'hA);
        repeat (5) step();
        n_tests++;
        if (obs_b.size() != 1) begin
            n_fail++; $display("FAIL msb_count got=%0d want=1", obs_b.size());
        end
        while (exp_b.size() != 0 && obs_b.size() != 0) begin
            e = exp_b.pop_front(); o = obs_b.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL msb_beat got=%h want=%h", o, e); end
        end
        exp_b.delete(); obs_b.delete();
        n_tests++;
        if (b_h !== 16'd3 || b_start_hi != 1) begin
            n_fail++; $display("FAIL msb_stats got h=%0d start=%0d want h=3 start=1", b_h, b_start_hi);
        end
    endtask

    task automatic test_backpressure();
        beat_t e, o, held;
        a_fv = 1'b0; step();
        a_fv = 1'b1; step();
        a_ready = 1'b0;
        drive_line(1'b0, 32, 32'h200);
        // The second word arrives while the first is still held, so it is lost.
        void'(exp_a.pop_back());
        held = exp_a[0];
        for (int r = 0; r < 2; r++) begin
            n_tests++;
            if ({a_valid, a_data, a_keep, a_last} !== {1'b1, held.d, held.k, held.l}) begin
                n_fail++;
                $display("FAIL bp_hold got valid=%b data=%h keep=%h last=%b want data=%h keep=%h last=%b",
                         a_valid, a_data, a_keep, a_last, held.d, held.k, held.l);
            end
            step();
        end
        n_tests++;
        if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL bp_ovf got=%b want=1", a_ovf); end
        a_ready = 1'b1;
        repeat (4) step();
        n_tests++;
        if (obs_a.size() != 1) begin
            n_fail++; $display("FAIL bp_count got=%0d want=1", obs_a.size());
        end
        while (exp_a.size() != 0 && obs_a.size() != 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL bp_beat got=%h want=%h", o, e); end
        end
        exp_a.delete(); obs_a.delete();
        a_fv = 1'b0; step();
        n_tests++;
        if (a_fb !== 32'd1 || a_ovf !== 1'b1) begin
            n_fail++; $display("FAIL bp_eof got fb=%0d ovf=%b want fb=1 ovf=1", a_fb, a_ovf);
        end
        a_fv = 1'b1; step();
        n_tests++;
        if (a_ovf !== 1'b0 || a_v !== 16'd0) begin
            n_fail++; $display("FAIL bp_sof got ovf=%b v=%0d want ovf=0 v=0", a_ovf, a_v);
        end
    endtask

    task automatic test_back_to_back();
        beat_t e, o;
        drive_line(1'b0, 48, 32'h1000);
        drive_line(1'b0, 48, 32'h2000);
        drive_line(1'b0, 48, 32'h3000);
        a_fv = 1'b0;
        repeat (6) step();
        n_tests++;
        if (obs_a.size() != 9) begin
            n_fail++; $display("FAIL b2b_count got=%0d want=9", obs_a.size());
        end
        while (exp_a.size() != 0 && obs_a.size() != 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_beat got=%h want=%h", o, e); end
        end
        exp_a.delete(); obs_a.delete();
        n_tests++;
        if (a_fb !== 32'd9 || a_v !== 16'd3) begin
            n_fail++; $display("FAIL b2b_stats got fb=%0d v=%0d want fb=9 v=3", a_fb, a_v);
        end
    endtask

    task automatic test_frame_cut();
        beat_t e, o;
        a_fv = 1'b1;
        step();
        model_line(1'b0, 1'b0, 5, 32'h500);
        for (int i = 0; i < 5; i++) begin
            a_dv = 1'b1; a_d = 32'h500 + i;
            step();
        end
        a_fv = 1'b0;
        step();
        a_dv = 1'b0;
        repeat (4) step();
        n_tests++;
        if (obs_a.size() != 1) begin
            n_fail++; $display("FAIL cut_count got=%0d want=1", obs_a.size());
        end
        while (exp_a.size() != 0 && obs_a.size() != 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL cut_beat got=%h want=%h", o, e); end
        end
        exp_a.delete(); obs_a.delete();
        n_tests++;
        if (a_fb !== 32'd1 || a_h !== 16'd5 || a_v !== 16'd1) begin
            n_fail++; $display("FAIL cut_stats got fb=%0d h=%0d v=%0d want fb=1 h=5 v=1", a_fb, a_h, a_v);
        end
    endtask

    task automatic test_reset_midline();
        beat_t e, o;
        a_fv = 1'b1;
        step();
        for (int i = 0; i < 7; i++) begin
            a_dv = 1'b1; a_d = 32'h600 + i;
            step();
        end
        rst = 1'b1; a_dv = 1'b0;
        step();
        n_tests++;
        if ({a_valid, a_data, a_keep, a_last, a_start, a_h, a_v, a_fb, a_ovf} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outs got valid=%b keep=%h h=%0d v=%0d fb=%0d want all zero",
                     a_valid, a_keep, a_h, a_v, a_fb);
        end
        rst = 1'b0;
        repeat (3) step();
        n_tests++;
        if (obs_a.size() != 0) begin
            n_fail++; $display("FAIL midreset_flush got=%0d words want=0", obs_a.size());
        end
        obs_a.delete();
        drive_line(1'b0, 16, 32'h700);
        repeat (6) step();
        n_tests++;
        if (obs_a.size() != 1) begin
            n_fail++; $display("FAIL midreset_count got=%0d want=1", obs_a.size());
        end
        while (exp_a.size() != 0 && obs_a.size() != 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL midreset_beat got=%h want=%h", o, e); end
        end
        exp_a.delete(); obs_a.delete();
        n_tests++;
        if (a_h !== 16'd16 || a_v !== 16'd1) begin
            n_fail++; $display("FAIL midreset_stats got h=%0d v=%0d want h=16 v=1", a_h, a_v);
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_partial();
        test_msb_first();
        test_backpressure();
        test_back_to_back();
        test_frame_cut();
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
